// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: register map, CTRL/STATUS bit positions and controller state encoding.
package timer_ctrl_pkg;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_LIMIT_L = 2'd1;
  localparam logic [1:0] ADDR_LIMIT_H = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_OPT = 1;
  localparam int CTRL_PSEL = 2;
  localparam int CTRL_IE = 5;
  localparam int STATUS_PEND = 0;
  localparam int STATUS_OVR = 1;
  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_QUIESCE} state_t;
endpackage

// File: rtl/timer_irq_pending.sv
// timer_irq_pending: pending/overrun event capture and registered CPU interrupt level.
module timer_irq_pending (
  input  logic clk,
  input  logic rst_n,
  input  logic timer_irq,
  input  logic clr_pend,
  input  logic clr_ovr,
  input  logic ie,
  output logic pend,
  output logic ovr,
  output logic cpu_irq
);
  // A new event wins over a same-cycle clear, and only counts as an overrun if PEND survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      ovr <= 1'b0;
      cpu_irq <= 1'b0;
    end else begin
      pend <= timer_irq | (pend & ~clr_pend);
      ovr <= ~clr_ovr & (ovr | (timer_irq & pend & ~clr_pend));
      cpu_irq <= pend & ie;
    end
  end
endmodule

// File: rtl/timer_config_controller.sv
// timer_config_controller: bus register file for a timer with atomic 16-bit limit commit,
// restart-on-reconfigure sequencing and pending-event interrupt status.
module timer_config_controller
  import timer_ctrl_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8,
  parameter int PRESCALER_WIDTH = 3,
  parameter logic [2*REGISTER_WIDTH-1:0] LIMIT_RESET = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [1:0] bus_addr,
  input  logic bus_wr,
  input  logic bus_rd,
  input  logic [REGISTER_WIDTH-1:0] bus_wdata,
  output logic [REGISTER_WIDTH-1:0] bus_rdata,
  output logic enable_interrupt,
  output logic interrupt_option,
  output logic [PRESCALER_WIDTH-1:0] prescaler_selector,
  output logic [2*REGISTER_WIDTH-1:0] timer_limit_value,
  input  logic timer_irq,
  output logic cpu_irq,
  input  logic cpu_irq_ack
);
  logic ctrl_en, ie, pend, ovr, reconf;
  logic [REGISTER_WIDTH-1:0] shadow, rd_val;
  state_t state;
  wire wr_ctrl = bus_wr & (bus_addr == ADDR_CTRL);
  wire wr_lo = bus_wr & (bus_addr == ADDR_LIMIT_L);
  wire wr_hi = bus_wr & (bus_addr == ADDR_LIMIT_H);
  wire wr_st = bus_wr & (bus_addr == ADDR_STATUS);
  // Anything that changes timer behaviour while enabled forces a prescaler restart.
  assign reconf = wr_hi | (wr_ctrl & bus_wdata[CTRL_EN] &
                  ((bus_wdata[CTRL_OPT] != interrupt_option) |
                   (bus_wdata[CTRL_PSEL +: PRESCALER_WIDTH] != prescaler_selector)));
  always_comb
    rd_val = (bus_addr == ADDR_CTRL) ? REGISTER_WIDTH'({ie, prescaler_selector, interrupt_option, ctrl_en}) :
             (bus_addr == ADDR_LIMIT_L) ? timer_limit_value[REGISTER_WIDTH-1:0] :
             (bus_addr == ADDR_LIMIT_H) ? timer_limit_value[2*REGISTER_WIDTH-1:REGISTER_WIDTH] :
             REGISTER_WIDTH'({ovr, pend});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en <= 1'b0;
      ie <= 1'b0;
      interrupt_option <= 1'b0;
      prescaler_selector <= '0;
      shadow <= '0;
      timer_limit_value <= LIMIT_RESET;
      bus_rdata <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= bus_wdata[CTRL_EN];
        interrupt_option <= bus_wdata[CTRL_OPT];
        prescaler_selector <= bus_wdata[CTRL_PSEL +: PRESCALER_WIDTH];
        ie <= bus_wdata[CTRL_IE];
      end
      if (wr_lo) shadow <= bus_wdata;
      if (wr_hi) timer_limit_value <= {bus_wdata, shadow};
      if (bus_rd) bus_rdata <= rd_val;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_OFF;
      enable_interrupt <= 1'b0;
    end else if (wr_ctrl & ~bus_wdata[CTRL_EN]) begin
      state <= ST_OFF;
      enable_interrupt <= 1'b0;
    end else if (state == ST_OFF) begin
      state <= wr_ctrl ? ST_RUN : ST_OFF;
      enable_interrupt <= wr_ctrl;
    end else begin
      state <= reconf ? ST_QUIESCE : ST_RUN;
      enable_interrupt <= ~reconf;
    end
  end
  timer_irq_pending u_pending (
    .clk(clk),
    .rst_n(rst_n),
    .timer_irq(timer_irq),
    .clr_pend(cpu_irq_ack | (wr_st & bus_wdata[STATUS_PEND])),
    .clr_ovr(wr_st & bus_wdata[STATUS_OVR]),
    .ie(ie),
    .pend(pend),
    .ovr(ovr),
    .cpu_irq(cpu_irq)
  );
endmodule

// File: tb/tb_timer_config_controller.sv
// tb_timer_config_controller: directed scenarios plus randomized traffic against a register-level reference model.
module tb_timer_config_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] bus_addr = '0;
  logic bus_wr = 1'b0, bus_rd = 1'b0, timer_irq = 1'b0, cpu_irq_ack = 1'b0;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic enable_interrupt, interrupt_option, cpu_irq;
  logic [2:0] prescaler_selector;
  logic [15:0] timer_limit_value;
  int checks = 0, errors = 0;
  bit m_en, m_opt, m_ie, m_pend, m_ovr, m_cpu, m_quiet;
  bit [2:0] m_psel;
  bit [7:0] m_shadow, m_rdata;
  bit [15:0] m_limit;

  timer_config_controller dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .enable_interrupt(enable_interrupt),
    .interrupt_option(interrupt_option), .prescaler_selector(prescaler_selector),
    .timer_limit_value(timer_limit_value), .timer_irq(timer_irq), .cpu_irq(cpu_irq),
    .cpu_irq_ack(cpu_irq_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    bit wc, wl, wh, ws, clr_p, reconf, was;
    @(posedge clk);
    if (!rst_n) begin
      {m_en, m_opt, m_ie, m_pend, m_ovr, m_cpu, m_quiet} = '0;
      m_psel = '0; m_shadow = '0; m_rdata = '0; m_limit = 16'hFFFF;
    end else begin
      wc = bus_wr && bus_addr == 2'd0;
      wl = bus_wr && bus_addr == 2'd1;
      wh = bus_wr && bus_addr == 2'd2;
      ws = bus_wr && bus_addr == 2'd3;
      if (bus_rd)
        case (bus_addr)
          2'd0: m_rdata = {2'b00, m_ie, m_psel, m_opt, m_en};
          2'd1: m_rdata = m_limit[7:0];
          2'd2: m_rdata = m_limit[15:8];
          default: m_rdata = {6'b0, m_ovr, m_pend};
        endcase
      clr_p = cpu_irq_ack || (ws && bus_wdata[0]);
      m_cpu = m_pend && m_ie;
      if (timer_irq && m_pend && !clr_p) m_ovr = 1;
      if (ws && bus_wdata[1]) m_ovr = 0;
      m_pend = timer_irq || (m_pend && !clr_p);
      reconf = wh || (wc && (bus_wdata[1] != m_opt || bus_wdata[4:2] != m_psel));
      was = m_en;
      if (wc) {m_ie, m_psel, m_opt, m_en} = bus_wdata[5:0];
      m_quiet = was && m_en && reconf;
      if (wl) m_shadow = bus_wdata;
      if (wh) m_limit = {bus_wdata, m_shadow};
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1; step(); bus_wr = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus_addr = a; bus_rd = 1; step(); bus_rd = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; step(); step(); rst_n = 1;
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL rst_en got %h exp 0", enable_interrupt); end
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL rst_cpu_irq got %h exp 0", cpu_irq); end
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", bus_rdata); end
    checks++; if (timer_limit_value !== 16'hFFFF) begin errors++; $display("FAIL rst_limit got %h exp ffff", timer_limit_value); end
    checks++; if ({interrupt_option, prescaler_selector} !== 4'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", {interrupt_option, prescaler_selector}); end
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", bus_rdata); end
  endtask

  task automatic test_ctrl();
    wr(2'd0, 8'h25);
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL ctrl_en got %h exp 1", enable_interrupt); end
    checks++; if (prescaler_selector !== 3'd1) begin errors++; $display("FAIL ctrl_psel got %h exp 1", prescaler_selector); end
    checks++; if (interrupt_option !== 1'b0) begin errors++; $display("FAIL ctrl_opt got %h exp 0", interrupt_option); end
    rd(2'd0);
    checks++; if (bus_rdata !== 8'h25) begin errors++; $display("FAIL ctrl_read got %h exp 25", bus_rdata); end
    wr(2'd0, 8'hE5);
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL ctrl_same_cfg_en got %h exp 1", enable_interrupt); end
    rd(2'd0);
    checks++; if (bus_rdata !== 8'h25) begin errors++; $display("FAIL ctrl_hi_bits got %h exp 25", bus_rdata); end
  endtask

  task automatic test_limit();
    wr(2'd1, 8'h34);
    checks++; if (timer_limit_value !== 16'hFFFF) begin errors++; $display("FAIL lim_shadow got %h exp ffff", timer_limit_value); end
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL lim_lo_en got %h exp 1", enable_interrupt); end
    wr(2'd2, 8'h12);
    checks++; if (timer_limit_value !== 16'h1234) begin errors++; $display("FAIL lim_commit got %h exp 1234", timer_limit_value); end
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL lim_quiesce got %h exp 0", enable_interrupt); end
    step();
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL lim_resume got %h exp 1", enable_interrupt); end
    rd(2'd1);
    checks++; if (bus_rdata !== 8'h34) begin errors++; $display("FAIL lim_rd_lo got %h exp 34", bus_rdata); end
    rd(2'd2);
    checks++; if (bus_rdata !== 8'h12) begin errors++; $display("FAIL lim_rd_hi got %h exp 12", bus_rdata); end
    wr(2'd1, 8'hAB); rd(2'd1);
    checks++; if (bus_rdata !== 8'h34) begin errors++; $display("FAIL lim_rd_committed got %h exp 34", bus_rdata); end
  endtask

  task automatic test_irq();
    timer_irq = 1; step(); timer_irq = 0;
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h01) begin errors++; $display("FAIL irq_pend got %h exp 01", bus_rdata); end
    checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL irq_cpu got %h exp 1", cpu_irq); end
    timer_irq = 1; step(); timer_irq = 0;
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h03) begin errors++; $display("FAIL irq_ovr got %h exp 03", bus_rdata); end
    wr(2'd3, 8'h03); step();
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_cpu got %h exp 0", cpu_irq); end
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL irq_w1c got %h exp 00", bus_rdata); end
  endtask

  task automatic test_ack_race();
    timer_irq = 1; step();
    cpu_irq_ack = 1; step();
    timer_irq = 0; cpu_irq_ack = 0;
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h01) begin errors++; $display("FAIL race_status got %h exp 01", bus_rdata); end
    cpu_irq_ack = 1; step(); cpu_irq_ack = 0;
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL ack_clear got %h exp 00", bus_rdata); end
  endtask

  task automatic test_rw_same();
    bus_addr = 2'd0; bus_wdata = 8'h01; bus_wr = 1; bus_rd = 1; step(); bus_wr = 0; bus_rd = 0;
    checks++; if (bus_rdata !== 8'h25) begin errors++; $display("FAIL rw_old got %h exp 25", bus_rdata); end
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL rw_psel_quiesce got %h exp 0", enable_interrupt); end
    checks++; if (prescaler_selector !== 3'd0) begin errors++; $display("FAIL rw_psel got %h exp 0", prescaler_selector); end
    rd(2'd0);
    checks++; if (bus_rdata !== 8'h01) begin errors++; $display("FAIL rw_new got %h exp 01", bus_rdata); end
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL rw_resume got %h exp 1", enable_interrupt); end
  endtask

  task automatic test_quiesce();
    wr(2'd0, 8'h05);
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL q_enter got %h exp 0", enable_interrupt); end
    wr(2'd2, 8'h00);
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL q_extend got %h exp 0", enable_interrupt); end
    checks++; if (timer_limit_value !== 16'h00AB) begin errors++; $display("FAIL q_limit got %h exp 00ab", timer_limit_value); end
    step();
    checks++; if (enable_interrupt !== 1'b1) begin errors++; $display("FAIL q_exit got %h exp 1", enable_interrupt); end
    wr(2'd0, 8'h21); wr(2'd0, 8'h20); step();
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL q_to_off got %h exp 0", enable_interrupt); end
    wr(2'd1, 8'h00); wr(2'd2, 8'h00);
    checks++; if (timer_limit_value !== 16'h0000) begin errors++; $display("FAIL limit_zero got %h exp 0000", timer_limit_value); end
  endtask

  task automatic test_reset_quiesce();
    wr(2'd0, 8'h25); wr(2'd1, 8'h77); wr(2'd2, 8'h55);
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL rq_pre got %h exp 0", enable_interrupt); end
    rst_n = 0; timer_irq = 1; bus_addr = 2'd0; bus_wdata = 8'h25; bus_wr = 1; bus_rd = 1;
    step();
    rst_n = 1; timer_irq = 0; bus_wr = 0; bus_rd = 0;
    checks++; if ({enable_interrupt, cpu_irq, interrupt_option, prescaler_selector} !== 6'h00) begin errors++; $display("FAIL rq_outs got %h exp 00", {enable_interrupt, cpu_irq, interrupt_option, prescaler_selector}); end
    checks++; if (timer_limit_value !== 16'hFFFF) begin errors++; $display("FAIL rq_limit got %h exp ffff", timer_limit_value); end
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rq_rdata got %h exp 00", bus_rdata); end
    step();
    checks++; if (enable_interrupt !== 1'b0) begin errors++; $display("FAIL rq_stay_off got %h exp 0", enable_interrupt); end
    wr(2'd2, 8'h12);
    checks++; if (timer_limit_value !== 16'h1200) begin errors++; $display("FAIL rq_shadow got %h exp 1200", timer_limit_value); end
    rd(2'd3);
    checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL rq_status got %h exp 00", bus_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      bus_wr = $urandom_range(0, 1);
      bus_rd = $urandom_range(0, 1);
      bus_addr = 2'($urandom_range(0, 3));
      bus_wdata = 8'($urandom);
      timer_irq = ($urandom_range(0, 3) == 0);
      cpu_irq_ack = ($urandom_range(0, 5) == 0);
      step();
      checks++; if (enable_interrupt !== (m_en && !m_quiet)) begin errors++; $display("FAIL rnd_en cyc %0d got %h exp %h", i, enable_interrupt, m_en && !m_quiet); end
      checks++; if (interrupt_option !== m_opt) begin errors++; $display("FAIL rnd_opt cyc %0d got %h exp %h", i, interrupt_option, m_opt); end
      checks++; if (prescaler_selector !== m_psel) begin errors++; $display("FAIL rnd_psel cyc %0d got %h exp %h", i, prescaler_selector, m_psel); end
      checks++; if (timer_limit_value !== m_limit) begin errors++; $display("FAIL rnd_limit cyc %0d got %h exp %h", i, timer_limit_value, m_limit); end
      checks++; if (cpu_irq !== m_cpu) begin errors++; $display("FAIL rnd_cpu_irq cyc %0d got %h exp %h", i, cpu_irq, m_cpu); end
      checks++; if (bus_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", i, bus_rdata, m_rdata); end
    end
    rst_n = 1; bus_wr = 0; bus_rd = 0; timer_irq = 0; cpu_irq_ack = 0;
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_limit();
    test_irq();
    test_ack_race();
    test_rw_same();
    test_quiesce();
    test_reset_quiesce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
